// File: rtl/move_input_ctrl.sv
// Player-side move source: debounces five buttons, keeps a 3x3 cursor and issues one-hot
// cell requests on C/writeEn, ending each one on acceptance, board clear or timeout.
`timescale 1ns/1ps
module move_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ACK_TIMEOUT     = 16,
  parameter int GAP_CYCLES      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic [8:0] X,
  input  logic [8:0] O,
  input  logic       gameOver,
  output logic [8:0] C,
  output logic       writeEn,
  output logic [3:0] cursor,
  output logic       busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(ACK_TIMEOUT);
  localparam logic [GW-1:0] GAP_V     = GW'(GAP_CYCLES);
  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_SEL = 4;

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  logic [4:0]    raw, sync_a, sync_b, deb, deb_d, press;
  logic [CW-1:0] cnt [5];

  assign raw   = {btn_sel, btn_right, btn_left, btn_down, btn_up};
  assign press = deb & ~deb_d;

  // Synchroniser and debounce: the level only follows sync_b after it has differed for DEBOUNCE_CYCLES clocks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
      deb    <= '0;
      deb_d  <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      deb_d  <= deb;
      for (int i = 0; i < 5; i++) begin
        if (sync_b[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          cnt[i] <= '0;
          deb[i] <= sync_b[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  state_t        state_q, state_d;
  logic [8:0]    c_q, c_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          nz_q, nz_d;
  logic [1:0]    row_q, row_d, col_q, col_d;
  logic [8:0]    occ;

  assign occ     = X | O;
  assign cursor  = ({2'b00, row_q} << 1) + {2'b00, row_q} + {2'b00, col_q};
  assign C       = c_q;
  assign writeEn = (state_q == DRIVE);
  assign busy    = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      timer_q <= '0;
      gap_q   <= '0;
      nz_q    <= 1'b0;
      row_q   <= 2'd1;
      col_q   <= 2'd1;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      nz_q    <= nz_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Abort only counts as a board clear if something was on the board when the request was issued
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    nz_d    = nz_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (press[B_SEL]) begin
          if (!gameOver && !occ[cursor]) begin
            state_d = DRIVE;
            c_d     = 9'b1 << cursor;
            timer_d = TW'(1);
            nz_d    = |occ;
          end
        end else if (press[B_UP]) begin
          row_d = (row_q == 2'd0) ? 2'd2 : row_q - 2'd1;
        end else if (press[B_DOWN]) begin
          row_d = (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;
        end else if (press[B_LEFT]) begin
          col_d = (col_q == 2'd0) ? 2'd2 : col_q - 2'd1;
        end else if (press[B_RIGHT]) begin
          col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
        end
      end
      DRIVE: begin
        if (timer_q != TW'(1) &&
            ((occ & c_q) != 9'd0 || (nz_q && occ == 9'd0) || timer_q >= TIMEOUT_V)) begin
          state_d = GAP;
          c_d     = '0;
          gap_d   = GW'(1);
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      GAP: begin
        if (gap_q >= GAP_V) state_d = IDLE;
        else                gap_d   = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_move_input_ctrl.sv
// Scoreboard bench for move_input_ctrl: stimulus queues expected requests and cursor steps,
// monitors pop and compare whenever the DUT shows a finished request or a cursor change.
`timescale 1ns/1ps
module tb_move_input_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] btn = '0;
  logic [8:0] X = '0;
  logic [8:0] O = '0;
  logic       gameOver = 1'b0;
  logic [8:0] C;
  logic       writeEn;
  logic [3:0] cursor;
  logic       busy;

  always #5 clk = ~clk;

  move_input_ctrl #(.DEBOUNCE_CYCLES(4), .ACK_TIMEOUT(16), .GAP_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]), .btn_sel(btn[4]),
    .X(X), .O(O), .gameOver(gameOver),
    .C(C), .writeEn(writeEn), .cursor(cursor), .busy(busy)
  );

  typedef struct {
    logic [8:0] c;
    int         high;
    int         gap;
  } req_t;

  req_t req_q[$];
  int   cur_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_reqs = 0;
  bit   mon_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic exp_req(input logic [8:0] c, input int high, input int gap);
    req_t r;
    r.c = c;
    r.high = high;
    r.gap = gap;
    req_q.push_back(r);
  endtask

  // Request monitor: measures each writeEn pulse and the busy-only gap that follows
  int         mode = 0;
  int         hi = 0;
  int         gp = 0;
  logic [8:0] cap = '0;
  bit         unstable = 1'b0;

  task automatic finish_req();
    req_t e;
    n_reqs++;
    if (req_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_req: got C=%0h high=%0d, expected no request", cap, hi);
    end else begin
      e = req_q.pop_front();
      check("req_c", int'(cap), int'(e.c));
      check("req_high", hi, e.high);
      check("req_gap", gp, e.gap);
      check("req_c_stable", int'(unstable), 0);
    end
    mode = 0;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      case (mode)
        0: if (writeEn) begin
             cap = C;
             hi = 1;
             unstable = 1'b0;
             mode = 1;
           end
        1: if (writeEn) begin
             hi++;
             if (C !== cap) unstable = 1'b1;
           end else if (busy) begin
             gp = 1;
             mode = 2;
           end else begin
             gp = 0;
             finish_req();
           end
        default: if (busy && !writeEn) gp++;
                 else finish_req();
      endcase
    end
  end

  logic [3:0] last_cur = 4'd4;

  always @(negedge clk) begin
    if (mon_on && cursor !== last_cur) begin
      if (cur_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_cursor: got %0d, expected no change from %0d", cursor, last_cur);
      end else begin
        check("cursor_step", int'(cursor), cur_q.pop_front());
      end
      last_cur = cursor;
    end
  end

  task automatic press(input int idx, output bit saw);
    saw = 1'b0;
    btn[idx] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (writeEn) saw = 1'b1;
    end
    btn[idx] = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (writeEn) saw = 1'b1;
    end
  endtask

  task automatic wait_we(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (writeEn) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected end of test");
    $fatal(1);
  end

  initial begin
    bit ok, saw;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_state", int'({cursor, C, writeEn, busy}), int'({4'd4, 9'd0, 2'b00}));
    end
    last_cur = 4'd4;
    mon_on = 1'b1;

    // Cursor wrap
    cur_q.push_back(5); press(3, saw);
    cur_q.push_back(3); press(3, saw);
    cur_q.push_back(0); press(0, saw);
    cur_q.push_back(6); press(0, saw);
    cur_q.push_back(0); press(1, saw);

    // Accepted move on cell 0
    exp_req(9'h001, 3, 4);
    btn[4] = 1'b1;
    wait_we(30, ok);
    check("we_rise_cell0", int'(ok), 1);
    repeat (2) @(negedge clk);
    X = 9'h001;
    repeat (8) @(negedge clk);
    btn[4] = 1'b0;
    repeat (20) @(negedge clk);
    check("busy_after_ack", int'(busy), 0);

    // Ignored selects
    press(4, saw);
    check("occupied_sel_we", int'(saw), 0);
    check("occupied_sel_c", int'(C), 0);
    cur_q.push_back(1); press(3, saw);
    gameOver = 1'b1;
    press(4, saw);
    check("gameover_sel_we", int'(saw), 0);
    check("gameover_sel_c", int'(C), 0);
    gameOver = 1'b0;

    // Timeout with no board update
    exp_req(9'h002, 16, 4);
    press(4, saw);
    repeat (30) @(negedge clk);
    check("busy_after_timeout", int'(busy), 0);

    // Bouncy select gives one request
    cur_q.push_back(2); press(3, saw);
    exp_req(9'h004, 16, 4);
    btn[4] = 1'b1;
    @(negedge clk);
    btn[4] = 1'b0;
    @(negedge clk);
    btn[4] = 1'b1;
    repeat (14) @(negedge clk);
    btn[4] = 1'b0;
    repeat (40) @(negedge clk);

    // Reset in the middle of a request
    cur_q.push_back(4);
    exp_req(9'h004, 4, 0);
    btn[4] = 1'b1;
    wait_we(30, ok);
    check("we_rise_reset_case", int'(ok), 1);
    btn[4] = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("reset_we_drop", int'(writeEn), 0);
    check("reset_c_clear", int'(C), 0);
    check("reset_busy_clear", int'(busy), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_cursor", int'(cursor), 4);
    check("post_reset_we", int'(writeEn), 0);

    check("req_queue_empty", req_q.size(), 0);
    check("cursor_queue_empty", cur_q.size(), 0);
    check("req_count", n_reqs, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
